// File: rtl/input_window_buffer.sv
// input_window_buffer
//   Streaming 3x3 sliding-window generator for raster-order RGB pixels.
//   A shift-register line buffer of 2*IMG_W+3 pixels feeds a zero-padded
//   (pad 1, stride 1) 3x3 neighbourhood for every pixel of the frame.
//   After the last pixel of a frame the block drains the remaining
//   IMG_W+1 windows by shifting zeros in.
// Ports:
//   Clk        clock, rising edge
//   Rst        synchronous active-high reset
//   data_in    input pixel (3 x fp32, channel 0 at LSBs)
//   valid_in   data_in present this cycle (ignored while busy)
//   busy       high while draining
//   data_out   3x3 window, element (i,j) at [(3*i+j)*DATA_W +: DATA_W]
//   valid_out  data_out/row_out/col_out valid
//   row_out    row of window centre
//   col_out    column of window centre
module input_window_buffer #(
  parameter int IMG_W  = 416,
  parameter int IMG_H  = 416,
  parameter int DATA_W = 96
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                valid_in,
  output logic                busy,
  output logic [9*DATA_W-1:0] data_out,
  output logic                valid_out,
  output logic [15:0]         row_out,
  output logic [15:0]         col_out
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int DEPTH = 2 * IMG_W + 3;
  localparam int CNT_W = $clog2(NPIX);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [15:0]         ctr_row_q, ctr_row_d;
  logic [15:0]         ctr_col_q, ctr_col_d;
  logic [DATA_W-1:0]   buf_q [DEPTH];
  logic [DATA_W-1:0]   buf_d [DEPTH];
  logic [9*DATA_W-1:0] win;
  logic [9*DATA_W-1:0] data_out_q, data_out_d;
  logic                valid_out_q, valid_out_d;
  logic                busy_q, busy_d;
  logic [15:0]         row_out_q, row_out_d;
  logic [15:0]         col_out_q, col_out_d;

  logic                accept, draining, shift, emit, last_ctr;
  logic                row_first, row_last, col_first, col_last;
  logic [DATA_W-1:0]   shift_in;

  assign draining  = (state_q == S_DRAIN);
  assign accept    = valid_in && !draining;
  assign shift     = accept || draining;
  assign emit      = draining || (accept && (state_q == S_STREAM));
  assign shift_in  = draining ? '0 : data_in;

  assign row_first = (ctr_row_q == 16'd0);
  assign row_last  = (ctr_row_q == 16'(IMG_H - 1));
  assign col_first = (ctr_col_q == 16'd0);
  assign col_last  = (ctr_col_q == 16'(IMG_W - 1));
  assign last_ctr  = row_last && col_last;

  // Next line-buffer contents; tap 0 is the newest pixel.
  assign buf_d[0] = shift ? shift_in : buf_q[0];
  for (genvar t = 1; t < DEPTH; t++) begin : g_shift
    assign buf_d[t] = shift ? buf_q[t-1] : buf_q[t];
  end

  // The window is taken from the post-shift buffer so the registered output
  // lines up with the pixel accepted on the same edge. The padding masks
  // also hide stale previous-frame data and the row wrap-around of the
  // linear buffer, which is why the buffer never needs clearing.
  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      localparam int TAP = 2 * IMG_W + 2 - gi * IMG_W - gj;
      logic pad;
      assign pad = ((gi == 0) && row_first) || ((gi == 2) && row_last) ||
                   ((gj == 0) && col_first) || ((gj == 2) && col_last);
      assign win[(3*gi+gj)*DATA_W +: DATA_W] = pad ? '0 : buf_d[TAP];
    end
  end

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    ctr_row_d   = ctr_row_q;
    ctr_col_d   = ctr_col_q;
    data_out_d  = data_out_q;
    row_out_d   = row_out_q;
    col_out_d   = col_out_q;
    valid_out_d = emit;

    case (state_q)
      S_FILL: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (in_cnt_q == CNT_W'(IMG_W)) state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (accept) begin
          if (in_cnt_q == CNT_W'(NPIX - 1)) begin
            state_d  = S_DRAIN;
            in_cnt_d = '0;
          end else begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (last_ctr) state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase

    // Centre counters wrap to (0,0) after the last centre of the frame.
    if (emit) begin
      data_out_d = win;
      row_out_d  = ctr_row_q;
      col_out_d  = ctr_col_q;
      if (col_last) begin
        ctr_col_d = '0;
        ctr_row_d = row_last ? 16'd0 : ctr_row_q + 16'd1;
      end else begin
        ctr_col_d = ctr_col_q + 16'd1;
      end
    end

    busy_d = (state_d == S_DRAIN);
  end

  always_ff @(posedge Clk) begin
    buf_q <= buf_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_FILL;
      in_cnt_q    <= '0;
      ctr_row_q   <= '0;
      ctr_col_q   <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
      row_out_q   <= '0;
      col_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      ctr_row_q   <= ctr_row_d;
      ctr_col_q   <= ctr_col_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      busy_q      <= busy_d;
      row_out_q   <= row_out_d;
      col_out_q   <= col_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign busy      = busy_q;
  assign row_out   = row_out_q;
  assign col_out   = col_out_q;

endmodule

// File: tb/tb_input_window_buffer.sv
module tb_input_window_buffer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 96;
  localparam int NP = W * H;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [DW-1:0]     data_in;
  logic              valid_in;
  logic              busy;
  logic [9*DW-1:0]   data_out;
  logic              valid_out;
  logic [15:0]       row_out;
  logic [15:0]       col_out;

  input_window_buffer #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in),
    .busy(busy), .data_out(data_out), .valid_out(valid_out),
    .row_out(row_out), .col_out(col_out)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Output capture, sampled on the falling edge.
  logic [9*DW-1:0] cap_data [256];
  int cap_row [256];
  int cap_col [256];
  int cap_cyc [256];
  int cap_n    = 0;
  int busy_cnt = 0;
  int n999     = 0;

  function automatic bit has999(input logic [9*DW-1:0] d);
    bit hit = 1'b0;
    for (int k = 0; k < 27; k++)
      if (d[k*32 +: 32] === 32'd999) hit = 1'b1;
    return hit;
  endfunction

  always @(negedge Clk) begin
    if (valid_out === 1'b1 && cap_n < 256) begin
      cap_data[cap_n] <= data_out;
      cap_row[cap_n]  <= int'(row_out);
      cap_col[cap_n]  <= int'(col_out);
      cap_cyc[cap_n]  <= cyc;
      cap_n           <= cap_n + 1;
    end
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (has999(data_out)) n999 <= n999 + 1;
  end

  function automatic logic [DW-1:0] pix(input int v);
    return {3{32'(v)}};
  endfunction

  // Reference window built directly from the frame definition.
  function automatic logic [9*DW-1:0] model_win(input int base, input int r, input int c);
    logic [9*DW-1:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int rr = r + i - 1;
        int cc = c + j - 1;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W)
          w[(3*i+j)*DW +: DW] = pix(base + rr * W + cc + 1);
      end
    return w;
  endfunction

  typedef struct packed {
    logic [1:0]        frm;
    logic [7:0]        row;
    logic [7:0]        col;
    logic [0:8][15:0]  v;
  } win_vec_t;

  win_vec_t tbl [7];
  int fstart [4];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_win(input string name, input int idx, input int r, input int c,
                         input logic [9*DW-1:0] exp);
    n_tests++;
    if (cap_row[idx] != r || cap_col[idx] != c || cap_data[idx] !== exp) begin
      int e = 0;
      n_fail++;
      for (int k = 8; k >= 0; k--)
        if (cap_data[idx][k*DW +: DW] !== exp[k*DW +: DW]) e = k;
      $display("FAIL %s: win %0d got centre (%0d,%0d) elem%0d=%0d, expected centre (%0d,%0d) elem%0d=%0d",
               name, idx, cap_row[idx], cap_col[idx], e, cap_data[idx][e*DW +: 32],
               r, c, e, exp[e*DW +: 32]);
    end
  endtask

  task automatic check_frame(input string name, input int fs, input int base);
    for (int k = 0; k < NP; k++)
      chk_win(name, fs + k, k / W, k % W, model_win(base, k / W, k % W));
  endtask

  task automatic drive_frame(input int base, input bit gap, output int acc5, output int acc_last);
    acc5 = 0;
    acc_last = 0;
    for (int p = 0; p < NP; p++) begin
      data_in  = pix(base + p + 1);
      valid_in = 1'b1;
      @(negedge Clk);
      if (p == W + 1) acc5 = cyc;
      if (p == NP - 1) acc_last = cyc;
      if (gap && p < NP - 1) begin
        valid_in = 1'b0;
        @(negedge Clk);
        chk("gap_idle_valid", longint'(valid_out), 0);
      end
    end
    valid_in = 1'b0;
    data_in  = '0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk(name, longint'(busy !== 1'b0), 0);
  endtask

  function automatic logic [9*DW-1:0] vec_win(input win_vec_t t);
    logic [9*DW-1:0] w = '0;
    for (int e = 0; e < 9; e++) w[e*DW +: DW] = pix(int'(t.v[e]));
    return w;
  endfunction

  initial begin
    int a5, al, idx, b0, bad;

    tbl[0] = '{frm: 2'd0, row: 8'd0, col: 8'd0, v: {16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd0, 16'd5, 16'd6}};
    tbl[1] = '{frm: 2'd0, row: 8'd1, col: 8'd1, v: {16'd1, 16'd2, 16'd3, 16'd5, 16'd6, 16'd7, 16'd9, 16'd10, 16'd11}};
    tbl[2] = '{frm: 2'd0, row: 8'd2, col: 8'd3, v: {16'd7, 16'd8, 16'd0, 16'd11, 16'd12, 16'd0, 16'd0, 16'd0, 16'd0}};
    tbl[3] = '{frm: 2'd0, row: 8'd0, col: 8'd3, v: {16'd0, 16'd0, 16'd0, 16'd3, 16'd4, 16'd0, 16'd7, 16'd8, 16'd0}};
    tbl[4] = '{frm: 2'd0, row: 8'd1, col: 8'd0, v: {16'd0, 16'd1, 16'd2, 16'd0, 16'd5, 16'd6, 16'd0, 16'd9, 16'd10}};
    tbl[5] = '{frm: 2'd0, row: 8'd2, col: 8'd0, v: {16'd0, 16'd5, 16'd6, 16'd0, 16'd9, 16'd10, 16'd0, 16'd0, 16'd0}};
    tbl[6] = '{frm: 2'd1, row: 8'd0, col: 8'd0, v: {16'd0, 16'd0, 16'd0, 16'd0, 16'd101, 16'd102, 16'd0, 16'd105, 16'd106}};

    Rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      bad = int'(data_out != '0) + int'(valid_out) + int'(busy) +
            int'(row_out != 16'd0) + int'(col_out != 16'd0);
      chk("idle_outputs_nonzero", bad, 0);
    end

    // Continuous frame
    idx = cap_n;
    b0  = busy_cnt;
    fstart[0] = idx;
    drive_frame(0, 1'b0, a5, al);
    wait_drain("cont_drain_timeout");
    @(negedge Clk);
    chk("cont_window_count", cap_n - idx, NP);
    chk("cont_first_latency", cap_cyc[idx] - a5, 0);
    chk("cont_last_latency", cap_cyc[idx + NP - 1] - al, W + 1);
    chk("cont_valid_contiguous", cap_cyc[idx + NP - 1] - cap_cyc[idx], NP - 1);
    chk("cont_busy_cycles", busy_cnt - b0, W + 1);
    check_frame("cont_win", idx, 0);

    // Gapped frame
    idx = cap_n;
    b0  = busy_cnt;
    drive_frame(0, 1'b1, a5, al);
    wait_drain("gap_drain_timeout");
    @(negedge Clk);
    chk("gap_window_count", cap_n - idx, NP);
    chk("gap_busy_cycles", busy_cnt - b0, W + 1);
    check_frame("gap_win", idx, 0);

    // Back-to-back frames, second starts the cycle after busy falls
    idx = cap_n;
    drive_frame(0, 1'b0, a5, al);
    wait_drain("b2b_drain1_timeout");
    fstart[1] = idx + NP;
    drive_frame(100, 1'b0, a5, al);
    wait_drain("b2b_drain2_timeout");
    @(negedge Clk);
    chk("b2b_window_count", cap_n - idx, 2 * NP);
    check_frame("b2b_f1_win", idx, 0);
    check_frame("b2b_f2_win", idx + NP, 100);

    // valid_in held during DRAIN with value 999
    idx = cap_n;
    drive_frame(0, 1'b0, a5, al);
    for (int i = 0; i < W + 1; i++) begin
      data_in  = pix(999);
      valid_in = 1'b1;
      @(negedge Clk);
    end
    chk("drop_busy_after_drain", longint'(busy), 0);
    drive_frame(0, 1'b0, a5, al);
    wait_drain("drop_drain_timeout");
    @(negedge Clk);
    chk("drop_window_count", cap_n - idx, 2 * NP);
    chk("drop_999_seen", n999, 0);
    check_frame("drop_next_win", idx + NP, 0);

    // Reset mid-frame after 7 pixels
    for (int p = 0; p < 7; p++) begin
      data_in  = pix(p + 1);
      valid_in = 1'b1;
      @(negedge Clk);
    end
    valid_in = 1'b0;
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("rst_clears_valid", longint'(valid_out), 0);
    @(negedge Clk);
    idx = cap_n;
    b0  = busy_cnt;
    drive_frame(0, 1'b0, a5, al);
    wait_drain("rst_drain_timeout");
    @(negedge Clk);
    chk("rst_window_count", cap_n - idx, NP);
    chk("rst_first_latency", cap_cyc[idx] - a5, 0);
    chk("rst_busy_cycles", busy_cnt - b0, W + 1);
    check_frame("rst_win", idx, 0);

    // Hand-computed windows
    for (int t = 0; t < 7; t++)
      chk_win("table_win", fstart[tbl[t].frm] + int'(tbl[t].row) * W + int'(tbl[t].col),
              int'(tbl[t].row), int'(tbl[t].col), vec_win(tbl[t]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
